// File: rtl/conv_pkg.sv
// Shared constants and feeder state encoding for the convolution engine and its frame feeder.
package conv_pkg;

  localparam int N  = 28;
  localparam int AW = 10;
  localparam int DW = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } feeder_state_e;

endpackage

// File: rtl/conv_pixel_feeder_if.sv
// Load/stream handshake between the frame feeder and its controller / engine.
interface conv_pixel_feeder_if
  import conv_pkg::*;
#(
  parameter int AW = conv_pkg::AW,
  parameter int DW = conv_pkg::DW
);

  logic          wr;
  logic [AW-1:0] wadr;
  logic [DW-1:0] wdata;
  logic          go;
  logic          busy;
  logic          start;
  logic [DW-1:0] datain;
  logic [AW-1:0] pix_idx;
  logic          frame_done;
  logic          wr_drop;

  modport master (
    output wr, wadr, wdata, go,
    input  busy, start, datain, pix_idx, frame_done, wr_drop
  );

  modport slave (
    input  wr, wadr, wdata, go,
    output busy, start, datain, pix_idx, frame_done, wr_drop
  );

endinterface

// File: rtl/frame_ram.sv
// Single-write-port frame memory with a registered (1-cycle latency) read port.
module frame_ram #(
  parameter int AW = 10,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wadr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] radr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[wadr] <= wdata;
    rdata_q <= mem[radr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/conv_pixel_feeder.sv
// Frame source for the convolution engine: stores one N x N image and streams it
// row-major after a one-cycle start pulse.
module conv_pixel_feeder
  import conv_pkg::*;
#(
  parameter int N  = conv_pkg::N,
  parameter int AW = conv_pkg::AW,
  parameter int DW = conv_pkg::DW
) (
  input logic                clk,
  input logic                rst,
  conv_pixel_feeder_if.slave bus
);

  localparam logic [AW-1:0] LAST_IDX  = AW'(N*N - 1);
  localparam logic [AW:0]   FRAME_LEN = (AW+1)'(N*N);

  feeder_state_e state_q, state_d;
  logic [AW-1:0] pix_idx_q, pix_idx_d;
  logic          start_q, start_d;
  logic          busy_q, busy_d;
  logic          frame_done_q, frame_done_d;
  logic          wr_drop_q, wr_drop_d;

  logic          streaming;
  logic          wr_ok;
  logic [AW-1:0] rd_adr;
  logic [DW-1:0] rd_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      pix_idx_q    <= '0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      wr_drop_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pix_idx_q    <= pix_idx_d;
      start_q      <= start_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      wr_drop_q    <= wr_drop_d;
    end
  end

  // Outputs are computed one cycle ahead so they leave the block straight from flops.
  always_comb begin
    state_d      = state_q;
    pix_idx_d    = '0;
    start_d      = 1'b0;
    busy_d       = 1'b0;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.go) begin
          state_d = START;
          start_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      START: begin
        state_d = STREAM;
        busy_d  = 1'b1;
      end
      STREAM: begin
        if (pix_idx_q == LAST_IDX) begin
          state_d      = DONE;
          frame_done_d = 1'b1;
        end else begin
          pix_idx_d = pix_idx_q + AW'(1);
          busy_d    = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Writes are locked out while the read side is walking the frame.
  always_comb begin
    streaming = (state_q == START) || (state_q == STREAM);
    wr_ok     = bus.wr && !streaming && ({1'b0, bus.wadr} < FRAME_LEN);
    wr_drop_d = bus.wr && !wr_ok;
    rd_adr    = (state_q == START) ? '0 : pix_idx_q + AW'(1);
  end

  frame_ram #(
    .AW (AW),
    .DW (DW)
  ) u_frame_ram (
    .clk   (clk),
    .we    (wr_ok),
    .wadr  (bus.wadr),
    .wdata (bus.wdata),
    .radr  (rd_adr),
    .rdata (rd_data)
  );

  assign bus.busy       = busy_q;
  assign bus.start      = start_q;
  assign bus.datain     = (state_q == STREAM) ? rd_data : '0;
  assign bus.pix_idx    = pix_idx_q;
  assign bus.frame_done = frame_done_q;
  assign bus.wr_drop    = wr_drop_q;

endmodule

// File: tb/tb_conv_pixel_feeder.sv
// Directed bench for conv_pixel_feeder: load, stream timing, ignored go, write drops,
// write+go ordering and asynchronous reset mid-frame.
module tb_conv_pixel_feeder;

  localparam int N   = 28;
  localparam int AW  = 10;
  localparam int DW  = 8;
  localparam int LEN = N * N;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  logic [DW-1:0] model [0:1023];

  conv_pixel_feeder_if #(.AW(AW), .DW(DW)) bus ();

  conv_pixel_feeder #(.N(N), .AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst       = 1'b0;
    bus.wr    = 1'b0;
    bus.wadr  = '0;
    bus.wdata = '0;
    bus.go    = 1'b0;
    tick();
    tick();
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    tests++; if (bus.start !== 1'b0) begin fails++; $display("FAIL reset_start got %b want 0", bus.start); end
    tests++; if (bus.datain !== 8'h00) begin fails++; $display("FAIL reset_datain got %h want 00", bus.datain); end
    tests++; if (bus.pix_idx !== 10'd0) begin fails++; $display("FAIL reset_pix_idx got %0d want 0", bus.pix_idx); end
    tests++; if (bus.frame_done !== 1'b0) begin fails++; $display("FAIL reset_frame_done got %b want 0", bus.frame_done); end
    tests++; if (bus.wr_drop !== 1'b0) begin fails++; $display("FAIL reset_wr_drop got %b want 0", bus.wr_drop); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_load;
    int drops;
    drops = 0;
    for (int j = 0; j < LEN; j++) begin
      bus.wr    = 1'b1;
      bus.wadr  = 10'(j);
      bus.wdata = 8'(j);
      model[j]  = 8'(j);
      tick();
      if (bus.wr_drop === 1'b1) drops++;
    end
    bus.wr = 1'b0;
    tick();
    if (bus.wr_drop === 1'b1) drops++;
    tests++; if (drops !== 0) begin fails++; $display("FAIL load_drops got %0d want 0", drops); end
  endtask

  // One full frame. go_at/wr_at: pixel index at which to inject a go or a write (-1 = none).
  task automatic test_stream(input string tag, input int go_at, input int wr_at, input bit go_in_done);
    bit wr_pending;
    wr_pending = 1'b0;
    tests++; if (bus.busy !== 1'b0 || bus.start !== 1'b0) begin fails++; $display("FAIL %s_idle busy/start got %b/%b want 0/0", tag, bus.busy, bus.start); end
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    tests++; if (bus.start !== 1'b1) begin fails++; $display("FAIL %s_start got %b want 1", tag, bus.start); end
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL %s_start_busy got %b want 1", tag, bus.busy); end
    tests++; if (bus.datain !== 8'h00) begin fails++; $display("FAIL %s_start_datain got %h want 00", tag, bus.datain); end
    for (int j = 0; j < LEN; j++) begin
      tick();
      tests++; if (bus.datain !== model[j]) begin fails++; $display("FAIL %s_pix[%0d] got %h want %h", tag, j, bus.datain, model[j]); end
      tests++; if (bus.pix_idx !== 10'(j)) begin fails++; $display("FAIL %s_idx[%0d] got %0d want %0d", tag, j, bus.pix_idx, j); end
      tests++; if (bus.busy !== 1'b1 || bus.start !== 1'b0) begin fails++; $display("FAIL %s_ctl[%0d] busy/start got %b/%b want 1/0", tag, j, bus.busy, bus.start); end
      if (wr_pending) begin
        tests++; if (bus.wr_drop !== 1'b1) begin fails++; $display("FAIL %s_busy_wr_drop got %b want 1", tag, bus.wr_drop); end
        wr_pending = 1'b0;
      end
      bus.go = 1'b0;
      bus.wr = 1'b0;
      if (j == go_at) bus.go = 1'b1;
      if (j == wr_at) begin
        bus.wr     = 1'b1;
        bus.wadr   = 10'd5;
        bus.wdata  = 8'hAA;
        wr_pending = 1'b1;
      end
    end
    bus.go = 1'b0;
    bus.wr = 1'b0;
    tick();
    tests++; if (bus.frame_done !== 1'b1) begin fails++; $display("FAIL %s_frame_done got %b want 1", tag, bus.frame_done); end
    tests++; if (bus.busy !== 1'b0 || bus.start !== 1'b0) begin fails++; $display("FAIL %s_done busy/start got %b/%b want 0/0", tag, bus.busy, bus.start); end
    tests++; if (bus.datain !== 8'h00 || bus.pix_idx !== 10'd0) begin fails++; $display("FAIL %s_done datain/idx got %h/%0d want 00/0", tag, bus.datain, bus.pix_idx); end
    if (go_in_done) begin
      bus.go = 1'b1;
      tick();
      tests++; if (bus.start !== 1'b0 || bus.busy !== 1'b0) begin fails++; $display("FAIL %s_go_in_done start/busy got %b/%b want 0/0", tag, bus.start, bus.busy); end
      tests++; if (bus.frame_done !== 1'b0) begin fails++; $display("FAIL %s_done_width got %b want 0", tag, bus.frame_done); end
    end
  endtask

  task automatic test_idle_writes;
    bus.wr    = 1'b1;
    bus.wadr  = 10'd800;
    bus.wdata = 8'h11;
    tick();
    bus.wr = 1'b0;
    tests++; if (bus.wr_drop !== 1'b1) begin fails++; $display("FAIL oob_wr_drop got %b want 1", bus.wr_drop); end
    tick();
    tests++; if (bus.wr_drop !== 1'b0) begin fails++; $display("FAIL oob_wr_drop_width got %b want 0", bus.wr_drop); end
    bus.wr    = 1'b1;
    bus.wadr  = 10'd783;
    bus.wdata = 8'd15;
    tick();
    bus.wr = 1'b0;
    tests++; if (bus.wr_drop !== 1'b0) begin fails++; $display("FAIL last_addr_wr_drop got %b want 0", bus.wr_drop); end
    tick();
  endtask

  task automatic test_wr_go;
    bus.wr    = 1'b1;
    bus.wadr  = 10'd0;
    bus.wdata = 8'h55;
    model[0]  = 8'h55;
  endtask

  task automatic test_async_reset;
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    for (int j = 0; j < 50; j++) tick();
    tests++; if (bus.busy !== 1'b1 || bus.datain !== model[49]) begin fails++; $display("FAIL pre_reset busy/datain got %b/%h want 1/%h", bus.busy, bus.datain, model[49]); end
    #3;
    rst = 1'b0;
    #1;
    tests++; if (bus.busy !== 1'b0 || bus.start !== 1'b0 || bus.frame_done !== 1'b0) begin fails++; $display("FAIL async_rst_ctl busy/start/done got %b/%b/%b want 0/0/0", bus.busy, bus.start, bus.frame_done); end
    tests++; if (bus.datain !== 8'h00 || bus.pix_idx !== 10'd0 || bus.wr_drop !== 1'b0) begin fails++; $display("FAIL async_rst_data datain/idx/drop got %h/%0d/%b want 00/0/0", bus.datain, bus.pix_idx, bus.wr_drop); end
    tick();
    tick();
    rst = 1'b1;
    tick();
    tests++; if (bus.busy !== 1'b0 || bus.start !== 1'b0) begin fails++; $display("FAIL post_reset busy/start got %b/%b want 0/0", bus.busy, bus.start); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_load();
    tick();
    test_stream("frame1", 200, -1, 1'b1);
    test_stream("back_to_back", -1, 100, 1'b0);
    tick();
    test_idle_writes();
    model[783] = 8'd15;
    test_wr_go();
    test_stream("wr_go", -1, -1, 1'b0);
    tick();
    test_async_reset();
    test_stream("after_reset", -1, -1, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/conv_pixel_feeder.md
# conv_pixel_feeder

Frame source for the 9-multiplier convolution engine: holds one N×N 8-bit image in an internal frame memory, loaded through a simple write port. On a `go` request it issues the engine's one-cycle `start` pulse. It then streams the image row-major, one pixel per clock, starting the cycle after `start`, with no gaps. It replaces the hand-driven `start`/`datain` stimulus and sits directly in front of `Conv` (its `start` and `datain` inputs).

## Interface
- `N`, 28, image side; frame length is N*N pixels.
- `AW`, 10, memory address width; N*N ≤ 2**AW is required.
- `DW`, 8, pixel width.

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `wr`  in  1  frame-memory write strobe.
- `wadr`  in  AW  write address.
- `wdata`  in  DW  write data.
- `go`  in  1  request to stream the stored frame.
- `busy`  out  1  high from the `start` cycle through the last pixel cycle.
- `start`  out  1  one-cycle start pulse to the engine.
- `datain`  out  DW  pixel stream to the engine.
- `pix_idx`  out  AW  index of the pixel currently on `datain`.
- `frame_done`  out  1  one-cycle pulse after the last pixel.
- `wr_drop`  out  1  one-cycle pulse when a write is rejected.

## Operation
- Frame memory: 2**AW × DW, one write port and one synchronous read port (1-cycle read latency).
- Writes occur only when not busy. A write while busy, or with `wadr` ≥ N*N, is discarded and pulses `wr_drop` in the following cycle.
- States: IDLE → START → STREAM → DONE → IDLE.
- IDLE: outputs quiet. `go`=1 moves to START.
- START (1 cycle): `start`=1, `busy`=1; read address 0 is issued.
- STREAM: each cycle presents pixel j on `datain` with `pix_idx`=j, and issues a read of j+1. After j = N*N−1 the state moves to DONE.
- DONE (1 cycle): `frame_done`=1, `busy`=0, `datain`=0; returns to IDLE.
- `go` while busy (START/STREAM/DONE) is ignored and not queued. `go` held high during DONE is also ignored; a new frame needs `go` sampled in IDLE.
- `go` and `wr` together in IDLE: the write completes in that cycle, and the stream (which starts reading 1 cycle later) sees the new data.
- `datain` and `pix_idx` are 0 whenever not in STREAM.
- Reset mid-frame: the FSM returns to IDLE immediately and all outputs go to 0. Memory contents are not cleared.
- Pixel index counter is AW bits. It never wraps inside a frame because the terminal count is N*N−1.

## Timing
- Reset values: `busy`=0, `start`=0, `datain`=0, `pix_idx`=0, `frame_done`=0, `wr_drop`=0.
- `go` sampled at edge k → `start`=1 during cycle k+1.
- Pixel j valid on `datain` during cycle k+2+j. Pixel 0 is the cycle after `start`, matching the engine's expectation.
- Last pixel is in cycle k+1+N*N. `frame_done` is in cycle k+2+N*N.
- Minimum `go`-to-`go` spacing: N*N+3 cycles.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package `conv_pkg`: `N`, `AW`, `DW` defaults and the feeder state enum (IDLE, START, STREAM, DONE). The engine uses the same constants.
- One sub-module, `frame_ram` (single write port, synchronous read port, parameterised `AW`/`DW`). The FSM, counter and drop logic stay in the top.

## Test plan
- Load mem[j] = j mod 256 for j = 0..783, pulse `go` at cycle 100. Required: `start` in cycle 101; `datain` = 0,1,…,255,0,… in cycles 102..885; `frame_done` in cycle 886; `busy` high in cycles 101..885.
- Pulse `go` again at cycle 300, during a stream. Required: no second `start`, stream unchanged. A `go` at cycle 887 starts a new frame with `start` in cycle 888.
- Write `wadr`=5, `wdata`=0xAA at cycle 400, during a stream. Required: `wr_drop` in cycle 401; mem[5] still 5 on the next frame. Also write `wadr`=800 while idle → `wr_drop`=1.
- `wr` (`wadr`=0, 0x55) and `go` in the same idle cycle. Required: first streamed pixel is 0x55.
- Assert `rst`=0 in the middle of cycle 500 (asynchronous). Required: all outputs 0 immediately. After release, a new `go` streams the original memory contents unchanged.
- Engine integration: feeder drives `Conv` #(28,10,8) with kernel all 0x0E. Required: engine `done` asserts and the readback matches the golden output file.
